// File: rtl/conforming_pkg.sv
// Shared types and constants for the conforming-filter trigger controller.
// Holds the controller state encoding, the default widths and the
// most-negative sample value used to seed the running peak.
package conforming_pkg;

    localparam int W_DEF       = 14;
    localparam int CW_DEF      = 10;
    localparam int CLR_CYC_DEF = 4;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHAPE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DEAD  = 3'd5
    } state_t;

    // Bit pattern of the most-negative two's-complement value of width w
    // (valid for w <= 32); callers cast it to their own width.
    function automatic logic [31:0] most_neg(input int w);
        return 32'(1) << (w - 1);
    endfunction

    localparam logic signed [W_DEF-1:0] PEAK_MIN = W_DEF'(most_neg(W_DEF));

endpackage

// File: rtl/conforming_ctrl_peak_hold.sv
// Signed running maximum with synchronous load-to-minimum.
// Ports:
//   clk_sys, rst_b : clock, asynchronous active-low reset (peak -> 0)
//   load           : seed peak with the most-negative value (wins over upd)
//   upd            : fold din into the running maximum
//   din            : signed sample
//   peak           : held maximum
module peak_hold
    import conforming_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                clk_sys,
    input  logic                rst_b,
    input  logic                load,
    input  logic                upd,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] peak
);

    localparam logic signed [W-1:0] MIN_VAL = W'(most_neg(W));

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            peak <= '0;
        end else if (load) begin
            peak <= MIN_VAL;
        end else if (upd && (din > peak)) begin
            peak <= din;
        end
    end

endmodule

// File: rtl/conforming_ctrl.sv
// Trigger / shaping-window / dead-time sequencer for a conforming filter.
// Ports:
//   CLK, CLR          : clock, asynchronous active-low reset
//   EN                : arms trigger acceptance
//   X, YF, THRESH     : raw sample, filter output, trigger threshold (signed)
//   WINDOW, DEAD      : shaping-window / dead-time lengths, latched at trigger
//   FILT_CLR, FILT_OE : filter clear / output-enable drives
//   PEAK, PILEUP      : held peak of YF and its pile-up flag
//   PEAK_VALID/READY  : result handshake
//   BUSY              : high outside IDLE and WAIT
//
// state | meaning
// INIT  | filter clear pulse after reset, CLR_CYC cycles
// IDLE  | disarmed, waiting for EN
// WAIT  | armed, waiting for X > THRESH
// SHAPE | filter enabled, tracking peak for the window length
// HOLD  | result presented until accepted
// DEAD  | filter clear for the dead time
module conforming_ctrl
    import conforming_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int CW      = CW_DEF,
    parameter int CLR_CYC = CLR_CYC_DEF
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                EN,
    input  logic signed [W-1:0] X,
    input  logic signed [W-1:0] YF,
    input  logic signed [W-1:0] THRESH,
    input  logic [CW-1:0]       WINDOW,
    input  logic [CW-1:0]       DEAD,
    output logic                FILT_CLR,
    output logic                FILT_OE,
    output logic signed [W-1:0] PEAK,
    output logic                PILEUP,
    output logic                PEAK_VALID,
    input  logic                PEAK_READY,
    output logic                BUSY
);

    localparam int             ICW       = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [ICW-1:0] INIT_LAST = ICW'(CLR_CYC - 1);

    state_t                state, state_nx;
    logic                  trig;
    logic [ICW-1:0]        init_cnt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         win_last;
    logic [CW-1:0]         dead_last;
    logic [CW-1:0]         dead_cnt;
    logic signed [W-1:0]   thr_q;
    logic                  below;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= ST_INIT;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        trig       = 1'b0;
        FILT_CLR   = 1'b0;
        FILT_OE    = 1'b0;
        PEAK_VALID = 1'b0;
        BUSY       = 1'b1;
        unique case (state)
            ST_INIT: begin
                FILT_CLR = 1'b1;
                if (init_cnt == INIT_LAST) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                BUSY = 1'b0;
                if (EN) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                BUSY = 1'b0;
                if (!EN) begin
                    state_nx = ST_IDLE;
                end else if (X > THRESH) begin
                    trig     = 1'b1;
                    state_nx = ST_SHAPE;
                end
            end
            ST_SHAPE: begin
                FILT_OE = 1'b1;
                if (cnt == win_last) state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                PEAK_VALID = 1'b1;
                if (PEAK_READY) state_nx = ST_DEAD;
            end
            ST_DEAD: begin
                FILT_CLR = 1'b1;
                if (dead_cnt == '0) state_nx = EN ? ST_WAIT : ST_IDLE;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    // Zero lengths are stored as "last index 0", i.e. one cycle.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            init_cnt  <= '0;
            cnt       <= '0;
            win_last  <= '0;
            dead_last <= '0;
            dead_cnt  <= '0;
            thr_q     <= '0;
            below     <= 1'b0;
            PILEUP    <= 1'b0;
        end else begin
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;

            if (trig) begin
                cnt       <= '0;
                win_last  <= (WINDOW == '0) ? '0 : WINDOW - 1'b1;
                dead_last <= (DEAD == '0) ? '0 : DEAD - 1'b1;
                thr_q     <= THRESH;
                below     <= 1'b0;
                PILEUP    <= 1'b0;
            end else if (state == ST_SHAPE) begin
                cnt <= cnt + 1'b1;
                // A re-crossing only counts after X has dropped back below.
                if (X <= thr_q)  below  <= 1'b1;
                else if (below)  PILEUP <= 1'b1;
            end

            if (state == ST_HOLD && PEAK_READY)
                dead_cnt <= dead_last;
            else if (state == ST_DEAD && dead_cnt != '0)
                dead_cnt <= dead_cnt - 1'b1;
        end
    end

    peak_hold #(.W(W)) u_peak_hold (
        .clk_sys (CLK),
        .rst_b   (CLR),
        .load    (trig),
        .upd     (state == ST_SHAPE),
        .din     (YF),
        .peak    (PEAK)
    );

endmodule

// File: tb/tb_conforming_ctrl.sv
module tb_conforming_ctrl;

    logic              CLK = 1'b0;
    logic              CLR = 1'b0;
    logic              EN = 1'b0;
    logic              PEAK_READY = 1'b0;
    logic signed [13:0] X = '0;
    logic signed [13:0] YF = '0;
    logic signed [13:0] THRESH = '0;
    logic [9:0]        WINDOW = '0;
    logic [9:0]        DEAD = '0;
    logic              FILT_CLR, FILT_OE, PILEUP, PEAK_VALID, BUSY;
    logic signed [13:0] PEAK;

    conforming_ctrl #(.W(14), .CW(10), .CLR_CYC(4)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .EN         (EN),
        .X          (X),
        .YF         (YF),
        .THRESH     (THRESH),
        .WINDOW     (WINDOW),
        .DEAD       (DEAD),
        .FILT_CLR   (FILT_CLR),
        .FILT_OE    (FILT_OE),
        .PEAK       (PEAK),
        .PILEUP     (PILEUP),
        .PEAK_VALID (PEAK_VALID),
        .PEAK_READY (PEAK_READY),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int peak;
        int pile;
        int vcyc;
    } exp_t;

    exp_t sb[$];
    bit   in_hold = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   xs[12];
    int   ys[12];
    int   fc;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs();
        @(negedge CLK);
        chk("rst_filt_clr", FILT_CLR, 1);
        chk("rst_filt_oe", FILT_OE, 0);
        chk("rst_peak", PEAK, 0);
        chk("rst_pileup", PILEUP, 0);
        chk("rst_valid", PEAK_VALID, 0);
        chk("rst_busy", BUSY, 1);
    endtask

    // Count FILT_CLR-high cycles over 8 cycles following a reset release.
    task automatic release_and_count();
        CLR = 1'b1;
        fc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            fc += int'(FILT_CLR);
            tick();
        end
        chk("init_clr_len", fc, 4);
        @(negedge CLK);
        chk("post_init_busy", BUSY, 0);
        tick();
    endtask

    // Called at the start of the trigger cycle (state WAIT). xs/ys give
    // X/YF for offsets 0 (trigger) .. weff+1 (first HOLD cycle).
    task automatic run_event(input int win, input int dd, input int ep,
                             input int epile, input bit drop_en);
        int weff;
        weff   = (win == 0) ? 1 : win;
        WINDOW = 10'(win);
        DEAD   = 10'(dd);
        sb.push_back('{ep, epile, cyc + weff + 1});
        for (int k = 0; k <= weff + 1; k++) begin
            X  = 14'(xs[k]);
            YF = 14'(ys[k]);
            if (drop_en && k == 1) EN = 1'b0;
            @(negedge CLK);
            if (k == 1)        chk("filt_oe_shape", FILT_OE, 1);
            if (k == weff + 1) chk("filt_oe_hold", FILT_OE, 0);
            tick();
        end
        X  = '0;
        YF = '0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge CLK);
                if (PEAK_VALID) begin
                    if (sb.size() == 0) begin
                        chk("spurious_valid", PEAK_VALID, 0);
                    end else begin
                        if (!in_hold) begin
                            chk("latency", cyc, sb[0].vcyc);
                            in_hold = 1'b1;
                        end
                        chk("peak", PEAK, sb[0].peak);
                        chk("pileup", PILEUP, sb[0].pile);
                        if (PEAK_READY) begin
                            void'(sb.pop_front());
                            in_hold = 1'b0;
                        end
                    end
                end
            end
        join_none

        // Reset state and start-up clear pulse
        THRESH = 14'sd100;
        repeat (3) tick();
        check_reset_outputs();
        tick();
        release_and_count();

        // Arm; trigger on the very next cycle (WAIT reached in one cycle)
        EN = 1'b1;
        PEAK_READY = 1'b1;
        tick();

        // A: single pulse, peak 900, no pile-up
        xs = '{1250, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ys = '{1000, 200, 500, 800, 900, 850, 700, 500, 300, 2000, 0, 0};
        run_event(8, 3, 900, 0, 1'b0);
        repeat (4) tick();

        // B: re-crossing at cnt=3 -> pile-up, window not restarted
        xs = '{1250, 0, 0, 0, 1250, 0, 0, 0, 0, 0, 0, 0};
        ys = '{0, -50, -20, 300, 150, 450, 449, 100, -300, 0, 0, 0};
        run_event(8, 3, 450, 1, 1'b0);
        repeat (4) tick();

        // C: all-negative YF, X held high (no pile-up, previous flag cleared),
        //    EN dropped mid-window without aborting
        xs = '{1250, 1250, 1250, 1250, 1250, 1250, 1250, 1250, 1250, 1250, 0, 0};
        ys = '{0, -500, -400, -300, -350, -600, -800, -8000, -1000, 500, 0, 0};
        run_event(8, 3, -300, 0, 1'b1);
        repeat (3) tick();
        X = 14'sd1250;
        repeat (6) tick();
        X = '0;
        EN = 1'b1;
        tick();

        // D: full-scale peak, READY held low 5 HOLD cycles, DEAD=3,
        //    X above threshold during DEAD must be ignored
        PEAK_READY = 1'b0;
        xs = '{1250, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ys = '{0, 100, 8191, -8192, 5, 6, 7, 8, 9, 0, 0, 0};
        run_event(8, 3, 8191, 0, 1'b0);
        repeat (4) tick();
        PEAK_READY = 1'b1;
        fc = 0;
        for (int k = 14; k < 22; k++) begin
            X = (k >= 15 && k <= 17) ? 14'sd1250 : 14'sd0;
            @(negedge CLK);
            if (k == 14) chk("hold_no_clr", FILT_CLR, 0);
            else         fc += int'(FILT_CLR);
            tick();
        end
        chk("dead_len3", fc, 3);

        // X equal to THRESH must not trigger
        X = 14'sd100;
        repeat (3) tick();

        // E: WINDOW=0/DEAD=0 behave as 1; X = THRESH+1 triggers
        xs = '{101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ys = '{0, -7, 99, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_event(0, 0, -7, 0, 1'b0);
        @(negedge CLK);
        chk("dead0_clr", FILT_CLR, 1);
        tick();
        @(negedge CLK);
        chk("dead0_done", FILT_CLR, 0);
        tick();

        // F: reset asserted mid-SHAPE discards the event
        X = 14'sd1250;
        WINDOW = 10'd8;
        tick();
        X = '0;
        repeat (3) tick();
        CLR = 1'b0;
        check_reset_outputs();
        tick();
        tick();
        release_and_count();

        // G: controller usable again after reset
        xs = '{1250, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ys = '{0, 5, 9, 4, 77, 0, 0, 0, 0, 0, 0, 0};
        run_event(3, 2, 9, 0, 1'b0);
        repeat (10) tick();

        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conforming_ctrl.md
CONFORMING_CTRL -- requirements
Module: conforming_ctrl

Interface
REQ-001 Parameter W, default 14: sample width of X and the filter output (signed two's complement).
REQ-002 Parameter CW, default 10: width of WINDOW and DEAD cycle counts.
REQ-003 Parameter CLR_CYC, default 4: length in cycles of the start-up filter-clear pulse.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 CLR  in  1  reset; asynchronous, active-low.
REQ-006 EN  in  1  arms trigger acceptance when high.
REQ-007 X  in  W  signed raw sample; the same signal that drives the conforming filter input.
REQ-008 YF  in  W  signed conforming-filter output.
REQ-009 THRESH  in  W  signed trigger threshold, sampled in WAIT.
REQ-010 WINDOW / DEAD  in  CW each  shaping-window length / dead-time length in cycles, sampled at trigger.
REQ-011 FILT_CLR / FILT_OE  out  1 each  drive the filter's CLR and OE inputs.
REQ-012 PEAK  out  W  signed held maximum of YF; PILEUP  out  1  pile-up flag for that peak.
REQ-013 PEAK_VALID  out  1 / PEAK_READY  in  1  result handshake; BUSY  out  1  high in all states except IDLE and WAIT.

Function
REQ-014 States: INIT, IDLE, WAIT, SHAPE, HOLD, DEAD; encoding defined in the package.
REQ-015 INIT: FILT_CLR=1 for CLR_CYC cycles, then IDLE.
REQ-016 IDLE -> WAIT when EN=1; WAIT -> IDLE when EN=0.
REQ-017 WAIT: trigger when X > THRESH (signed, strict); next cycle in SHAPE with cnt=0, peak=most-negative W-bit value, FILT_OE=1, and WINDOW/DEAD latched.
REQ-018 SHAPE: each cycle peak <= max(peak, YF); cnt increments; leave for HOLD on the cycle cnt == max(WINDOW,1)-1 (WINDOW=0 treated as 1).
REQ-019 Pile-up: in SHAPE, X falling to <= THRESH sets an internal below flag; a later X > THRESH while the flag is set sets PILEUP; the window is not restarted.
REQ-020 HOLD: FILT_OE=0, PEAK_VALID=1; PEAK and PILEUP stay stable until PEAK_VALID && PEAK_READY, and that cycle transitions to DEAD.
REQ-021 PEAK_READY may already be high on HOLD entry; the transfer then completes in 1 cycle.
REQ-022 DEAD: FILT_CLR=1 for max(DEAD,1) cycles, then WAIT if EN=1, else IDLE.
REQ-023 EN=0 during SHAPE/HOLD/DEAD does not abort; the event completes normally.
REQ-024 Triggers outside WAIT are ignored and are not counted.
REQ-025 Trigger-to-PEAK_VALID latency = WINDOW+1 cycles.
REQ-026 PILEUP is cleared on the next trigger.

Reset
REQ-027 While CLR=0: state=INIT, INIT counter=0, FILT_CLR=1, FILT_OE=0, PEAK=0, PILEUP=0, PEAK_VALID=0, BUSY=1.
REQ-028 CLR asserted mid-event discards the event with no handshake; after release, INIT reruns in full.

Structure
REQ-029 Package conforming_pkg holds the state enum, the W/CW defaults and the most-negative-value constant.
REQ-030 Sub-module peak_hold (signed running max with synchronous load-to-minimum) is instantiated once.

Verification
REQ-031 Reset release -> FILT_CLR high exactly 4 cycles, then IDLE; with EN=1, WAIT on the next cycle.
REQ-032 THRESH=100, WINDOW=8, one X pulse of 1250, YF ramping to 900 then decaying, READY=1 -> PEAK_VALID at trigger+9, PEAK=900, PILEUP=0.
REQ-033 Same setup, X returns to 0 and then hits 1250 again at cnt=3 -> PILEUP=1, PEAK valid still at trigger+9.
REQ-034 READY held low 5 cycles in HOLD -> PEAK/PILEUP stable all 5 cycles; DEAD entered on the cycle after READY rises; DEAD=3 gives 3 FILT_CLR cycles.
REQ-035 X > THRESH during DEAD -> ignored; the next trigger is accepted only in WAIT.
REQ-036 CLR pulsed low in SHAPE -> all outputs at reset values; no PEAK_VALID; INIT reruns.
